// File: rtl/mc_pkg.sv
// mc_pkg
// Shared definitions for the multicycle MIPS-subset sequencer and its
// instruction decoder.
//   - Opcode and funct field values for the supported instructions
//   - Sequencer state encoding
//   - ALU operation select values
//   - Instruction class and static strobe bundle produced by mc_decode
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_JUMP    = 3'd0,
        CLS_BRANCH  = 3'd1,
        CLS_ALU     = 3'd2,
        CLS_LUI     = 3'd3,
        CLS_LOAD    = 3'd4,
        CLS_STORE   = 3'd5,
        CLS_ILLEGAL = 3'd6
    } inst_class_t;

    // Strobes that depend only on the instruction, not on the step it is in.
    // The sequencer decides in which state each of them is allowed through.
    typedef struct packed {
        logic jump;
        logic beq;
        logic write2rt;
        logic imm2alu;
        logic write_imm;
        logic read_data;
        logic mem_we;
        logic alu_op;
    } static_strobes_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode
// Pure combinational instruction decoder. Classifies the instruction held in
// the IR and produces the per-instruction datapath strobes. The same block is
// used by the single-cycle control unit, which applies the strobes directly.
// Ports:
//   inst        in  32  instruction word (opcode inst[31:26], funct inst[5:0])
//   inst_class  out     instruction class, CLS_ILLEGAL if undecodable
//   strobes     out     static datapath strobes for this instruction
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0]     inst,
    output inst_class_t     inst_class,
    output static_strobes_t strobes
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = inst[31:26];
    assign funct         = inst[5:0];
    assign unused_fields = ^inst[25:6];

    // Register fields and immediates are routed straight to the datapath, so
    // only opcode and funct matter here. Any opcode/funct pair not listed
    // falls through to CLS_ILLEGAL with every strobe low.
    always_comb begin
        inst_class = CLS_ILLEGAL;
        strobes    = '0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADDU) begin
                    inst_class     = CLS_ALU;
                    strobes.alu_op = ALU_ADD;
                end else if (funct == FN_SUBU) begin
                    inst_class     = CLS_ALU;
                    strobes.alu_op = ALU_SUB;
                end
            end
            OP_J: begin
                inst_class   = CLS_JUMP;
                strobes.jump = 1'b1;
            end
            OP_BEQ: begin
                inst_class     = CLS_BRANCH;
                strobes.beq    = 1'b1;
                strobes.alu_op = ALU_SUB;
            end
            OP_ADDIU: begin
                inst_class       = CLS_ALU;
                strobes.write2rt = 1'b1;
                strobes.imm2alu  = 1'b1;
                strobes.alu_op   = ALU_ADD;
            end
            OP_LUI: begin
                inst_class        = CLS_LUI;
                strobes.write2rt  = 1'b1;
                strobes.write_imm = 1'b1;
            end
            OP_LW: begin
                inst_class        = CLS_LOAD;
                strobes.write2rt  = 1'b1;
                strobes.imm2alu   = 1'b1;
                strobes.read_data = 1'b1;
                strobes.alu_op    = ALU_ADD;
            end
            OP_SW: begin
                inst_class      = CLS_STORE;
                strobes.imm2alu = 1'b1;
                strobes.mem_we  = 1'b1;
                strobes.alu_op  = ALU_ADD;
            end
            default: begin
                inst_class = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl
// Multicycle sequencer for the MIPS-subset datapath. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, waits on the instruction and data memory
// acknowledges, and gates the decoder's strobes so that register, memory and
// PC writes each happen in exactly one step.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   inst                  IR contents, stable from DECODE onward
//   if_ack, mem_ack       memory acknowledges (ignored outside FETCH / MEM)
//   if_req, ir_we         instruction fetch request and IR load enable
//   pc_we                 PC load enable, only ever together with retire
//   mem_req               data memory request
//   cu_*                  datapath strobes, same meaning as the old control unit
//   retire, retired_cnt   completion pulse and wrapping completion counter
//   trap                  set while stopped on an illegal instruction
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int TRAP_ON_ILLEGAL = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             if_ack,
    input  logic             mem_ack,
    output logic             if_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             mem_req,
    output logic             cu_jump,
    output logic             cu_beq,
    output logic             cu_write2rt,
    output logic             cu_imm2alu,
    output logic             cu_write_imm,
    output logic             cu_read_data,
    output logic             cu_reg_we,
    output logic             cu_mem_we,
    output logic             cu_alu_op,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             trap
);

    state_t          state;
    state_t          next_state;
    inst_class_t     inst_class;
    static_strobes_t st;

    mc_decode u_decode (
        .inst       (inst),
        .inst_class (inst_class),
        .strobes    (st)
    );

    // State register. Reset drops any in-flight request because every request
    // output is decoded from the state and IDLE drives nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Retired-instruction counter; wraps naturally at the top of its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and output decode. Every step that finishes an instruction
    // raises pc_we and retire together, so the PC only advances on completion.
    // Acks are looked at only in the state that issued the matching request.
    always_comb begin
        next_state   = state;
        if_req       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        mem_req      = 1'b0;
        cu_jump      = 1'b0;
        cu_beq       = 1'b0;
        cu_write2rt  = 1'b0;
        cu_imm2alu   = 1'b0;
        cu_write_imm = 1'b0;
        cu_read_data = 1'b0;
        cu_reg_we    = 1'b0;
        cu_mem_we    = 1'b0;
        cu_alu_op    = ALU_ADD;
        retire       = 1'b0;
        trap         = 1'b0;

        case (state)
            IDLE: begin
                next_state = FETCH;
            end

            FETCH: begin
                if_req = 1'b1;
                if (if_ack) begin
                    ir_we      = 1'b1;
                    next_state = DECODE;
                end
            end

            DECODE: begin
                case (inst_class)
                    CLS_JUMP: begin
                        cu_jump    = st.jump;
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end
                    CLS_BRANCH: begin
                        cu_beq     = st.beq;
                        cu_alu_op  = st.alu_op;
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end
                    CLS_ALU, CLS_LUI: begin
                        next_state = EXEC;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        next_state = MEM;
                    end
                    default: begin
                        if (TRAP_ON_ILLEGAL != 0) begin
                            next_state = TRAP;
                        end else begin
                            pc_we      = 1'b1;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end
                    end
                endcase
            end

            EXEC: begin
                cu_write2rt  = st.write2rt;
                cu_imm2alu   = st.imm2alu;
                cu_write_imm = st.write_imm;
                cu_alu_op    = st.alu_op;
                cu_reg_we    = 1'b1;
                pc_we        = 1'b1;
                retire       = 1'b1;
                next_state   = FETCH;
            end

            MEM: begin
                mem_req    = 1'b1;
                cu_imm2alu = st.imm2alu;
                cu_alu_op  = st.alu_op;
                cu_mem_we  = st.mem_we;
                if (mem_ack) begin
                    if (inst_class == CLS_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WB;
                    end
                end
            end

            WB: begin
                cu_write2rt  = st.write2rt;
                cu_read_data = st.read_data;
                cu_reg_we    = 1'b1;
                pc_we        = 1'b1;
                retire       = 1'b1;
                next_state   = FETCH;
            end

            TRAP: begin
                trap       = 1'b1;
                next_state = TRAP;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
